dfd_tnif_tx: RTL and testbench
==============================

# dfd_tnif_tx

Core-side transmitter for the trace network interface (TNIF). It accepts N-trace and DST trace beats from a core's trace encoders and buffers each source in its own FIFO. It arbitrates the two sources onto the single `MS_TN_Vld/Src/Data` channel toward `dfd_trace_network` and honours the network's grant, per-source backpressure and per-source flush requests. One instance sits at each core's TNIF boundary.

## Interface
- `DATA_WIDTH_IN_BYTES`, 16: trace beat width in bytes.
- `DATA_WIDTH`, `DATA_WIDTH_IN_BYTES*8`: trace beat width in bits.
- `FIFO_DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ntr_vld`  in  1  N-trace beat valid from the encoder.
- `ntr_data`  in  DATA_WIDTH  N-trace beat.
- `ntr_rdy`  out  1  N-trace beat accepted when `ntr_vld & ntr_rdy`.
- `dst_vld`  in  1  DST beat valid.
- `dst_data`  in  DATA_WIDTH  DST beat.
- `dst_rdy`  out  1  DST beat accepted when `dst_vld & dst_rdy`.
- `MS_TN_Vld`  out  1  beat offered to the trace network.
- `MS_TN_Src`  out  1  source of the offered beat: 0 = N-trace, 1 = DST.
- `MS_TN_Data`  out  DATA_WIDTH  offered beat.
- `TN_MS_Gnt`  in  1  network accepts the offered beat this cycle.
- `TN_MS_Ntrace_Bp` / `TN_MS_Dst_Bp`  in  1 each  per-source backpressure.
- `TN_MS_Ntrace_Flush` / `TN_MS_Dst_Flush`  in  1 each  per-source flush request; level.
- `ntr_flush_done` / `dst_flush_done`  out  1 each  that source is fully drained while its flush request is high.

## Operation
- Input side:
  - `ntr_rdy = !ntr_full & !TN_MS_Ntrace_Flush`. `dst_rdy` is defined the same way for DST.
  - `rdy` depends only on the full flag. A full FIFO deasserts `rdy` even if it is being popped in the same cycle; there is no pass-through.
- FIFOs:
  - Circular buffers with `$clog2(FIFO_DEPTH)+1`-bit read and write pointers.
  - The extra MSB distinguishes full from empty.
  - Pointers wrap modulo `2*FIFO_DEPTH`.
- Output stage: a holding register containing `out_vld`, `out_src` and `out_data`, which drive `MS_TN_Vld`, `MS_TN_Src` and `MS_TN_Data` directly.
- Load condition: `load_ok = !out_vld | TN_MS_Gnt`.
- Eligibility: a source is eligible when its FIFO is non-empty and its Bp input is 0 in the current cycle.
- Arbitration:
  - If exactly one source is eligible and `load_ok`, pop that FIFO into the holding register.
  - If both are eligible, a round-robin pointer `rr` picks the source: 0 favours N-trace. After each load `rr` points to the other source.
  - Reset value of `rr` is 0.
  - If `load_ok` and neither source is eligible, `out_vld` clears once the current beat is granted.
- Handshake:
  - Once `MS_TN_Vld` is asserted, `Vld`, `Src` and `Data` stay stable until the cycle in which `TN_MS_Gnt` = 1.
  - A beat is never retracted, including when Bp or Flush rises after it was loaded.
  - `TN_MS_Gnt` while `MS_TN_Vld` = 0 is ignored.
- Flush:
  - While a source's Flush is high, its input `rdy` is 0 and its FIFO keeps draining normally, subject to its Bp.
  - `x_flush_done = x_Flush & x_fifo_empty & !(out_vld & out_src == x)`. It is combinational and drops with Flush.
- Reset: async clear of both FIFO pointers, `out_vld`, `rr`. Reset values:
  - `MS_TN_Vld`=0, `MS_TN_Src`=0, `MS_TN_Data`=0.
  - `ntr_rdy`=1, `dst_rdy`=1, qualified by Flush inputs.
  - Flush-done outputs follow the combinational equation; with pipeline empty they equal the Flush inputs.
- Reset mid-transfer: buffered and offered beats are discarded; no partial beat is emitted after release.

## Timing
- Input accepted in cycle N → the FIFO head is visible in N+1 → loaded at the end of N+1 → `MS_TN_Vld`=1 in N+2.
- Minimum latency is 2 cycles.
- With `TN_MS_Gnt` held at 1 and data available, throughput is 1 beat per cycle, and `MS_TN_Vld` stays high continuously.
- Bp is sampled only when choosing the next load: a Bp rising in cycle N blocks loads from that source starting at the end of N.
- Flush rising in cycle N sets that source's `rdy`=0 in cycle N.
- FIFO full to accepting: after a pop at the end of N, `rdy` = 1 in N+1.

## Test plan
- Single N-trace beat `0xA5..A5`, `Gnt` held high → `MS_TN_Vld`=1 exactly 2 cycles after acceptance, `Src`=0, data matches; then `Vld`=0.
- Both sources push 4 beats each (FIFO_DEPTH=4), `Gnt`=1 → output order N0,D0,N1,D1,N2,D2,N3,D3; 8 consecutive valid cycles.
- Offer a beat with `Gnt`=0 for 5 cycles, toggling `TN_MS_Ntrace_Bp` and data inputs meanwhile → `Vld`/`Src`/`Data` held unchanged until `Gnt`; transfer on the first `Gnt` cycle.
- `TN_MS_Dst_Bp`=1 with both FIFOs loaded → only N-trace beats emitted; DST beats resume in round-robin order after Bp drops.
- Fill the DST FIFO to 4 with `Gnt`=0 → `dst_rdy`=0; assert `TN_MS_Dst_Flush`, then `Gnt`=1 → 4 DST beats drain, `dst_flush_done` rises the cycle after the last DST grant, `dst_rdy` stays 0 until Flush drops.
- Assert `reset` with 3 beats buffered and `Vld` high → `MS_TN_Vld`=0 immediately (async); after release no stale beats are emitted and new input appears with 2-cycle latency.

Source files
------------

// File: rtl/dfd_tnif_tx.sv
// Core-side trace network transmitter: buffers N-trace and DST beats in
// per-source FIFOs and round-robins them onto the single MS_TN channel.
module dfd_tnif_tx #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int DATA_WIDTH          = DATA_WIDTH_IN_BYTES * 8,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ntr_vld,
    input  logic [DATA_WIDTH-1:0] ntr_data,
    output logic                  ntr_rdy,
    input  logic                  dst_vld,
    input  logic [DATA_WIDTH-1:0] dst_data,
    output logic                  dst_rdy,
    output logic                  MS_TN_Vld,
    output logic                  MS_TN_Src,
    output logic [DATA_WIDTH-1:0] MS_TN_Data,
    input  logic                  TN_MS_Gnt,
    input  logic                  TN_MS_Ntrace_Bp,
    input  logic                  TN_MS_Dst_Bp,
    input  logic                  TN_MS_Ntrace_Flush,
    input  logic                  TN_MS_Dst_Flush,
    output logic                  ntr_flush_done,
    output logic                  dst_flush_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    // Handshake: input beats transfer on vld & rdy; an offered MS_TN beat holds
    // Vld/Src/Data stable until the cycle TN_MS_Gnt is high, and is never retracted.

    logic [DATA_WIDTH-1:0] ntr_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] dst_mem_q [FIFO_DEPTH];
    logic [PW-1:0]         ntr_wr_q, ntr_wr_d, ntr_rd_q, ntr_rd_d;
    logic [PW-1:0]         dst_wr_q, dst_wr_d, dst_rd_q, dst_rd_d;
    logic                  out_vld_q, out_vld_d;
    logic                  out_src_q, out_src_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  rr_q, rr_d;

    logic                  ntr_full, ntr_empty, dst_full, dst_empty;
    logic                  ntr_push, dst_push, ntr_pop, dst_pop;
    logic                  ntr_elig, dst_elig, load_ok, load, sel_dst;
    logic [DATA_WIDTH-1:0] ntr_head, dst_head;

    // The pointer MSB separates full (MSBs differ, indices equal) from empty.
    assign ntr_empty = (ntr_wr_q == ntr_rd_q);
    assign ntr_full  = (ntr_wr_q[PW-1] != ntr_rd_q[PW-1]) &&
                       (ntr_wr_q[AW-1:0] == ntr_rd_q[AW-1:0]);
    assign dst_empty = (dst_wr_q == dst_rd_q);
    assign dst_full  = (dst_wr_q[PW-1] != dst_rd_q[PW-1]) &&
                       (dst_wr_q[AW-1:0] == dst_rd_q[AW-1:0]);

    assign ntr_rdy  = !ntr_full && !TN_MS_Ntrace_Flush;
    assign dst_rdy  = !dst_full && !TN_MS_Dst_Flush;
    assign ntr_push = ntr_vld && ntr_rdy;
    assign dst_push = dst_vld && dst_rdy;

    assign ntr_head = ntr_mem_q[ntr_rd_q[AW-1:0]];
    assign dst_head = dst_mem_q[dst_rd_q[AW-1:0]];

    always_comb begin
        ntr_elig = !ntr_empty && !TN_MS_Ntrace_Bp;
        dst_elig = !dst_empty && !TN_MS_Dst_Bp;
        load_ok  = !out_vld_q || TN_MS_Gnt;
        sel_dst  = (ntr_elig && dst_elig) ? rr_q : dst_elig;
        load     = load_ok && (ntr_elig || dst_elig);
        ntr_pop  = load && !sel_dst;
        dst_pop  = load && sel_dst;

        ntr_wr_d = ntr_wr_q + PW'(ntr_push);
        ntr_rd_d = ntr_rd_q + PW'(ntr_pop);
        dst_wr_d = dst_wr_q + PW'(dst_push);
        dst_rd_d = dst_rd_q + PW'(dst_pop);

        out_vld_d  = out_vld_q;
        out_src_d  = out_src_q;
        out_data_d = out_data_q;
        rr_d       = rr_q;
        if (load) begin
            out_vld_d  = 1'b1;
            out_src_d  = sel_dst;
            out_data_d = sel_dst ? dst_head : ntr_head;
            rr_d       = !sel_dst;
        end else if (load_ok) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ntr_wr_q   <= '0;
            ntr_rd_q   <= '0;
            dst_wr_q   <= '0;
            dst_rd_q   <= '0;
            out_vld_q  <= 1'b0;
            out_src_q  <= 1'b0;
            out_data_q <= '0;
            rr_q       <= 1'b0;
        end else begin
            ntr_wr_q   <= ntr_wr_d;
            ntr_rd_q   <= ntr_rd_d;
            dst_wr_q   <= dst_wr_d;
            dst_rd_q   <= dst_rd_d;
            out_vld_q  <= out_vld_d;
            out_src_q  <= out_src_d;
            out_data_q <= out_data_d;
            rr_q       <= rr_d;
        end
    end

    // Storage needs no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (ntr_push) ntr_mem_q[ntr_wr_q[AW-1:0]] <= ntr_data;
        if (dst_push) dst_mem_q[dst_wr_q[AW-1:0]] <= dst_data;
    end

    assign MS_TN_Vld  = out_vld_q;
    assign MS_TN_Src  = out_src_q;
    assign MS_TN_Data = out_data_q;

    assign ntr_flush_done = TN_MS_Ntrace_Flush && ntr_empty && !(out_vld_q && !out_src_q);
    assign dst_flush_done = TN_MS_Dst_Flush && dst_empty && !(out_vld_q && out_src_q);

endmodule

// File: tb/tb_dfd_tnif_tx.sv
// Directed bench for dfd_tnif_tx: reset, latency, interleaving, hold under
// no-grant, backpressure, flush drain and mid-transfer reset.
module tb_dfd_tnif_tx;
    localparam int DW = 128;

    logic          clk;
    logic          reset;
    logic          ntr_vld, dst_vld;
    logic [DW-1:0] ntr_data, dst_data;
    logic          ntr_rdy, dst_rdy;
    logic          MS_TN_Vld, MS_TN_Src;
    logic [DW-1:0] MS_TN_Data;
    logic          TN_MS_Gnt, TN_MS_Ntrace_Bp, TN_MS_Dst_Bp;
    logic          TN_MS_Ntrace_Flush, TN_MS_Dst_Flush;
    logic          ntr_flush_done, dst_flush_done;

    int            checks_total;
    int            checks_passed;
    logic [DW-1:0] exp_q[$];
    logic          exp_src_q[$];
    logic [DW-1:0] e_data;
    logic          e_src;
    int            first_c, last_c;

    dfd_tnif_tx dut (
        .clk                (clk),
        .reset              (reset),
        .ntr_vld            (ntr_vld),
        .ntr_data           (ntr_data),
        .ntr_rdy            (ntr_rdy),
        .dst_vld            (dst_vld),
        .dst_data           (dst_data),
        .dst_rdy            (dst_rdy),
        .MS_TN_Vld          (MS_TN_Vld),
        .MS_TN_Src          (MS_TN_Src),
        .MS_TN_Data         (MS_TN_Data),
        .TN_MS_Gnt          (TN_MS_Gnt),
        .TN_MS_Ntrace_Bp    (TN_MS_Ntrace_Bp),
        .TN_MS_Dst_Bp       (TN_MS_Dst_Bp),
        .TN_MS_Ntrace_Flush (TN_MS_Ntrace_Flush),
        .TN_MS_Dst_Flush    (TN_MS_Dst_Flush),
        .ntr_flush_done     (ntr_flush_done),
        .dst_flush_done     (dst_flush_done)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [7:0] tag, input int i);
        return {tag, {11{8'h5A}}, 32'(i)};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ntr_vld = 1'b0; ntr_data = '0; dst_vld = 1'b0; dst_data = '0;
        TN_MS_Gnt = 1'b0; TN_MS_Ntrace_Bp = 1'b0; TN_MS_Dst_Bp = 1'b0;
        TN_MS_Ntrace_Flush = 1'b0; TN_MS_Dst_Flush = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        checks_total++;
        if (MS_TN_Vld !== 1'b0) $display("FAIL reset_vld: got %b expected 0", MS_TN_Vld); else checks_passed++;
        checks_total++;
        if (MS_TN_Src !== 1'b0) $display("FAIL reset_src: got %b expected 0", MS_TN_Src); else checks_passed++;
        checks_total++;
        if (MS_TN_Data !== '0) $display("FAIL reset_data: got %h expected 0", MS_TN_Data); else checks_passed++;
        checks_total++;
        if ({ntr_rdy, dst_rdy} !== 2'b11) $display("FAIL reset_rdy: got %b expected 11", {ntr_rdy, dst_rdy}); else checks_passed++;
        checks_total++;
        if ({ntr_flush_done, dst_flush_done} !== 2'b00) $display("FAIL reset_fdone: got %b expected 00", {ntr_flush_done, dst_flush_done}); else checks_passed++;
        TN_MS_Ntrace_Flush = 1'b1;
        TN_MS_Dst_Flush = 1'b1;
        #1;
        checks_total++;
        if ({ntr_rdy, dst_rdy} !== 2'b00) $display("FAIL reset_flush_rdy: got %b expected 00", {ntr_rdy, dst_rdy}); else checks_passed++;
        checks_total++;
        if ({ntr_flush_done, dst_flush_done} !== 2'b11) $display("FAIL reset_flush_fdone: got %b expected 11", {ntr_flush_done, dst_flush_done}); else checks_passed++;
        do_reset();
    endtask

    task automatic test_single_latency();
        do_reset();
        TN_MS_Gnt = 1'b1;
        ntr_vld = 1'b1;
        ntr_data = {16{8'hA5}};
        #1;
        checks_total++;
        if (ntr_rdy !== 1'b1) $display("FAIL single_rdy: got %b expected 1", ntr_rdy); else checks_passed++;
        tick();
        ntr_vld = 1'b0;
        ntr_data = '0;
        checks_total++;
        if (MS_TN_Vld !== 1'b0) $display("FAIL single_vld_n1: got %b expected 0", MS_TN_Vld); else checks_passed++;
        tick();
        checks_total++;
        if ({MS_TN_Vld, MS_TN_Src} !== 2'b10) $display("FAIL single_vld_n2: got vld/src %b expected 10", {MS_TN_Vld, MS_TN_Src}); else checks_passed++;
        checks_total++;
        if (MS_TN_Data !== {16{8'hA5}}) $display("FAIL single_data: got %h expected a5..a5", MS_TN_Data); else checks_passed++;
        tick();
        checks_total++;
        if (MS_TN_Vld !== 1'b0) $display("FAIL single_vld_after: got %b expected 0", MS_TN_Vld); else checks_passed++;
    endtask

    task automatic test_interleave();
        do_reset();
        TN_MS_Gnt = 1'b1;
        exp_q.delete(); exp_src_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(8'h11, i)); exp_src_q.push_back(1'b0);
            exp_q.push_back(mk(8'h22, i)); exp_src_q.push_back(1'b1);
        end
        first_c = -1; last_c = -1;
        for (int c = 0; c < 16; c++) begin
            if (MS_TN_Vld === 1'b1) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                checks_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL interleave_extra: got src %b data %h expected no beat", MS_TN_Src, MS_TN_Data);
                end else begin
                    e_data = exp_q.pop_front(); e_src = exp_src_q.pop_front();
                    if (MS_TN_Data !== e_data || MS_TN_Src !== e_src)
                        $display("FAIL interleave_beat: got src %b data %h expected src %b data %h", MS_TN_Src, MS_TN_Data, e_src, e_data);
                    else checks_passed++;
                end
            end
            ntr_vld = (c < 4); ntr_data = mk(8'h11, c);
            dst_vld = (c < 4); dst_data = mk(8'h22, c);
            tick();
        end
        checks_total++;
        if (exp_q.size() != 0) $display("FAIL interleave_count: got %0d beats missing expected 0", exp_q.size()); else checks_passed++;
        checks_total++;
        if (first_c != 2) $display("FAIL interleave_latency: got first valid at %0d expected 2", first_c); else checks_passed++;
        checks_total++;
        if (last_c - first_c != 7) $display("FAIL interleave_continuous: got span %0d expected 7", last_c - first_c); else checks_passed++;
    endtask

    task automatic test_hold_no_grant();
        do_reset();
        ntr_vld = 1'b1; ntr_data = mk(8'h33, 0);
        tick();
        ntr_vld = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks_total++;
            if (MS_TN_Vld !== 1'b1 || MS_TN_Src !== 1'b0 || MS_TN_Data !== mk(8'h33, 0))
                $display("FAIL hold_stable: got vld %b src %b data %h expected 1 0 %h", MS_TN_Vld, MS_TN_Src, MS_TN_Data, mk(8'h33, 0));
            else checks_passed++;
            TN_MS_Ntrace_Bp = (i % 2 == 1);
            ntr_vld = (i == 1);
            ntr_data = (i == 1) ? mk(8'h33, 1) : DW'($urandom_range(0, 65535));
            dst_data = DW'($urandom_range(0, 65535));
            tick();
        end
        ntr_vld = 1'b0;
        TN_MS_Ntrace_Bp = 1'b0;
        TN_MS_Gnt = 1'b1;
        tick();
        checks_total++;
        if (MS_TN_Vld !== 1'b1 || MS_TN_Data !== mk(8'h33, 1))
            $display("FAIL hold_next: got vld %b data %h expected 1 %h", MS_TN_Vld, MS_TN_Data, mk(8'h33, 1));
        else checks_passed++;
        tick();
        checks_total++;
        if (MS_TN_Vld !== 1'b0) $display("FAIL hold_empty: got %b expected 0", MS_TN_Vld); else checks_passed++;
        TN_MS_Gnt = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        TN_MS_Gnt = 1'b1;
        exp_q.delete(); exp_src_q.delete();
        exp_q.push_back(mk(8'h44, 0)); exp_src_q.push_back(1'b0);
        exp_q.push_back(mk(8'h44, 1)); exp_src_q.push_back(1'b0);
        exp_q.push_back(mk(8'h55, 0)); exp_src_q.push_back(1'b1);
        exp_q.push_back(mk(8'h44, 2)); exp_src_q.push_back(1'b0);
        exp_q.push_back(mk(8'h55, 1)); exp_src_q.push_back(1'b1);
        exp_q.push_back(mk(8'h44, 3)); exp_src_q.push_back(1'b0);
        exp_q.push_back(mk(8'h55, 2)); exp_src_q.push_back(1'b1);
        for (int c = 0; c < 14; c++) begin
            if (MS_TN_Vld === 1'b1) begin
                checks_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_extra: got src %b data %h expected no beat", MS_TN_Src, MS_TN_Data);
                end else begin
                    e_data = exp_q.pop_front(); e_src = exp_src_q.pop_front();
                    if (MS_TN_Data !== e_data || MS_TN_Src !== e_src)
                        $display("FAIL bp_beat: got src %b data %h expected src %b data %h", MS_TN_Src, MS_TN_Data, e_src, e_data);
                    else checks_passed++;
                end
            end
            ntr_vld = (c < 4); ntr_data = mk(8'h44, c);
            dst_vld = (c < 3); dst_data = mk(8'h55, c);
            TN_MS_Dst_Bp = (c < 3);
            tick();
        end
        checks_total++;
        if (exp_q.size() != 0) $display("FAIL bp_count: got %0d beats missing expected 0", exp_q.size()); else checks_passed++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            dst_vld = 1'b1; dst_data = mk(8'h66, c);
            tick();
        end
        checks_total++;
        if (dst_rdy !== 1'b0) $display("FAIL flush_full_rdy: got %b expected 0", dst_rdy); else checks_passed++;
        checks_total++;
        if (MS_TN_Vld !== 1'b1 || MS_TN_Src !== 1'b1 || MS_TN_Data !== mk(8'h66, 0))
            $display("FAIL flush_head: got vld %b src %b data %h expected 1 1 %h", MS_TN_Vld, MS_TN_Src, MS_TN_Data, mk(8'h66, 0));
        else checks_passed++;
        dst_data = mk(8'h77, 0);
        tick();
        dst_vld = 1'b0;
        TN_MS_Dst_Flush = 1'b1;
        #1;
        checks_total++;
        if ({dst_rdy, dst_flush_done, ntr_flush_done} !== 3'b000)
            $display("FAIL flush_start: got rdy/done/ntr_done %b expected 000", {dst_rdy, dst_flush_done, ntr_flush_done});
        else checks_passed++;
        tick();
        TN_MS_Gnt = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            tick();
            checks_total++;
            if (j < 5) begin
                if (MS_TN_Vld !== 1'b1 || MS_TN_Src !== 1'b1 || MS_TN_Data !== mk(8'h66, j) || dst_flush_done !== 1'b0 || dst_rdy !== 1'b0)
                    $display("FAIL flush_drain: got vld %b src %b data %h done %b rdy %b expected 1 1 %h 0 0", MS_TN_Vld, MS_TN_Src, MS_TN_Data, dst_flush_done, dst_rdy, mk(8'h66, j));
                else checks_passed++;
            end else begin
                if (MS_TN_Vld !== 1'b0 || dst_flush_done !== 1'b1 || dst_rdy !== 1'b0)
                    $display("FAIL flush_done: got vld %b done %b rdy %b expected 0 1 0", MS_TN_Vld, dst_flush_done, dst_rdy);
                else checks_passed++;
            end
        end
        tick();
        checks_total++;
        if ({MS_TN_Vld, dst_flush_done, dst_rdy} !== 3'b010)
            $display("FAIL flush_hold: got vld/done/rdy %b expected 010", {MS_TN_Vld, dst_flush_done, dst_rdy});
        else checks_passed++;
        TN_MS_Dst_Flush = 1'b0;
        #1;
        checks_total++;
        if ({dst_rdy, dst_flush_done} !== 2'b10) $display("FAIL flush_release: got rdy/done %b expected 10", {dst_rdy, dst_flush_done}); else checks_passed++;
        TN_MS_Gnt = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            ntr_vld = 1'b1; ntr_data = mk(8'h88, c);
            tick();
        end
        ntr_vld = 1'b0;
        checks_total++;
        if (MS_TN_Vld !== 1'b1) $display("FAIL rstmid_pre_vld: got %b expected 1", MS_TN_Vld); else checks_passed++;
        #2;
        reset = 1'b1;
        #1;
        checks_total++;
        if (MS_TN_Vld !== 1'b0 || MS_TN_Data !== '0) $display("FAIL rstmid_async: got vld %b data %h expected 0 0", MS_TN_Vld, MS_TN_Data); else checks_passed++;
        tick(); tick();
        reset = 1'b0;
        TN_MS_Gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks_total++;
            if (MS_TN_Vld !== 1'b0) $display("FAIL rstmid_stale: got vld %b data %h expected 0", MS_TN_Vld, MS_TN_Data); else checks_passed++;
        end
        ntr_vld = 1'b1; ntr_data = mk(8'h99, 0);
        tick();
        ntr_vld = 1'b0;
        checks_total++;
        if (MS_TN_Vld !== 1'b0) $display("FAIL rstmid_new_n1: got %b expected 0", MS_TN_Vld); else checks_passed++;
        tick();
        checks_total++;
        if (MS_TN_Vld !== 1'b1 || MS_TN_Src !== 1'b0 || MS_TN_Data !== mk(8'h99, 0))
            $display("FAIL rstmid_new_n2: got vld %b src %b data %h expected 1 0 %h", MS_TN_Vld, MS_TN_Src, MS_TN_Data, mk(8'h99, 0));
        else checks_passed++;
        tick();
        TN_MS_Gnt = 1'b0;
    endtask

    initial begin
        checks_total = 0;
        checks_passed = 0;
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_single_latency();
        test_interleave();
        test_hold_no_grant();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
